// File: rtl/dot_acc_sequencer_pkg.sv
// Shared types and defaults for the interleaved dot-product accumulator.
package dot_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam int ACCU_WIDTH_DEF = 32;
    localparam int PIPE_LAT_DEF   = 8;

    function automatic int slot_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dot_acc_sequencer_if.sv
// Job control, vector stream, dot-engine and result stream signals.
interface dot_acc_sequencer_if
    import dot_pkg::*;
#(
    parameter int ACCU_WIDTH = ACCU_WIDTH_DEF,
    parameter int PIPE_LAT   = PIPE_LAT_DEF,
    parameter int KW         = 16
) ();
    localparam int SW = slot_w(PIPE_LAT);

    logic                  start;
    logic [KW-1:0]         k_len;
    logic                  in_valid;
    logic                  in_ready;
    logic                  dot_ena;
    logic [ACCU_WIDTH-1:0] dot_acc;
    logic [ACCU_WIDTH-1:0] dot_result;
    logic                  out_valid;
    logic                  out_ready;
    logic [ACCU_WIDTH-1:0] out_data;
    logic [SW-1:0]         out_slot;
    logic                  done;

    modport slave (
        input  start, k_len, in_valid, dot_result, out_ready,
        output in_ready, dot_ena, dot_acc, out_valid, out_data, out_slot, done
    );

    modport master (
        output start, k_len, in_valid, dot_result, out_ready,
        input  in_ready, dot_ena, dot_acc, out_valid, out_data, out_slot, done
    );

endinterface

// File: rtl/dot_acc_out_fifo.sv
// Result FIFO; head is forced to zero while empty.
module dot_acc_out_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
    localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && ((count != FULL) || do_pop);
    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop)
                rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (!do_push && do_pop)
                count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/dot_acc_sequencer.sv
// Interleaves PIPE_LAT accumulations through a fixed-latency dot engine,
// feeding each slot's previous partial sum back as the seed.
module dot_acc_sequencer
    import dot_pkg::*;
#(
    parameter int ACCU_WIDTH = ACCU_WIDTH_DEF,
    parameter int PIPE_LAT   = PIPE_LAT_DEF,
    parameter int KW         = 16
) (
    input logic                clk,
    input logic                rst,
    dot_acc_sequencer_if.slave bus
);
    localparam int SW = slot_w(PIPE_LAT);
    localparam logic [SW-1:0] LAST = SW'(PIPE_LAT - 1);

    state_t        state;
    state_t        state_nx;
    logic [SW-1:0] slot;
    logic [KW-1:0] step;
    logic [KW-1:0] k_last;
    logic [PIPE_LAT-1:0] tag_v;
    logic [SW-1:0] tag_s [PIPE_LAT];
    logic          final_step;
    logic          in_ready;
    logic          accept;
    logic          dot_ena;
    logic          push;
    logic          fifo_empty;
    logic          done;
    logic [SW+ACCU_WIDTH-1:0] fifo_q;

    assign final_step = (step == k_last);
    // Final round only opens once the previous job's results are drained.
    assign in_ready = (state == RUN) &&
                      !(final_step && slot == '0 && !fifo_empty);
    assign accept   = bus.in_valid && in_ready;
    assign dot_ena  = (state == FLUSH) || accept;
    assign push     = dot_ena && tag_v[PIPE_LAT-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        done     = 1'b0;
        unique case (state)
            IDLE:  if (bus.start) state_nx = RUN;
            RUN:   if (accept && final_step && slot == LAST) state_nx = FLUSH;
            FLUSH: if (slot == LAST) begin
                state_nx = IDLE;
                done     = 1'b1;
            end
            default: state_nx = IDLE;
        endcase
    end

    // slot doubles as the flush cycle counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot   <= '0;
            step   <= '0;
            k_last <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    slot <= '0;
                    step <= '0;
                    if (bus.start)
                        k_last <= (bus.k_len == '0) ? '0 : bus.k_len - 1'b1;
                end
                RUN: if (accept) begin
                    if (slot == LAST) begin
                        slot <= '0;
                        step <= final_step ? '0 : step + 1'b1;
                    end else begin
                        slot <= slot + 1'b1;
                    end
                end
                FLUSH: slot <= (slot == LAST) ? '0 : slot + 1'b1;
                default: begin
                    slot <= '0;
                    step <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_v <= '0;
            for (int i = 0; i < PIPE_LAT; i++) tag_s[i] <= '0;
        end else if (dot_ena) begin
            for (int i = PIPE_LAT - 1; i > 0; i--) begin
                tag_v[i] <= tag_v[i-1];
                tag_s[i] <= tag_s[i-1];
            end
            tag_v[0] <= accept && final_step;
            tag_s[0] <= slot;
        end
    end

    dot_acc_out_fifo #(
        .WIDTH(SW + ACCU_WIDTH),
        .DEPTH(PIPE_LAT)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({tag_s[PIPE_LAT-1], bus.dot_result}),
        .pop       (bus.out_ready),
        .pop_data  (fifo_q),
        .empty     (fifo_empty)
    );

    assign bus.in_ready  = in_ready;
    assign bus.dot_ena   = dot_ena;
    assign bus.dot_acc   = (state == RUN && step != '0) ? bus.dot_result : '0;
    assign bus.out_valid = !fifo_empty;
    assign bus.out_data  = fifo_q[ACCU_WIDTH-1:0];
    assign bus.out_slot  = fifo_q[ACCU_WIDTH +: SW];
    assign bus.done      = done;

endmodule

// File: tb/tb_dot_acc_sequencer.sv
// Directed bench: dot-engine model, per-slot sum model and scoreboard.
module tb_dot_acc_sequencer;
    import dot_pkg::*;

    localparam int AW = 32;
    localparam int L  = 8;
    localparam int KW = 16;

    typedef struct {
        logic [AW-1:0] d;
        logic [2:0]    s;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dot_acc_sequencer_if #(.ACCU_WIDTH(AW), .PIPE_LAT(L), .KW(KW)) bus ();

    dot_acc_sequencer #(.ACCU_WIDTH(AW), .PIPE_LAT(L), .KW(KW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Dot engine: L enabled cycles from seed+product to result.
    logic [AW-1:0] pipe [L];
    logic [AW-1:0] cur_prod;
    assign bus.dot_result = pipe[L-1];
    always @(posedge clk) begin
        if (bus.dot_ena) begin
            for (int i = L - 1; i > 0; i--) pipe[i] <= pipe[i-1];
            pipe[0] <= bus.dot_acc + cur_prod;
        end
    end

    // Slot sums: vector n goes to slot n%L; last L vectors are results.
    logic [AW-1:0] sums [L];
    logic [AW-1:0] prod_tab [64];
    exp_t exp_q [$];
    int   k_eff;
    int   acc_idx;
    bit   feeding = 0;
    int   done_cnt = 0;

    always @(negedge clk) begin
        if (rst && feeding) begin
            if (!bus.in_valid)
                chk("idle_dot_ena", bus.dot_ena, 0);
            else if (bus.in_ready) begin
                int s;
                logic [AW-1:0] ea;
                s  = acc_idx % L;
                ea = (acc_idx < L) ? '0 : sums[s];
                chk("acc_dot_ena", bus.dot_ena, 1);
                chk("dot_acc", bus.dot_acc, ea);
                sums[s] = ea + cur_prod;
                if (acc_idx >= (k_eff - 1) * L)
                    exp_q.push_back('{d: sums[s], s: 3'(s)});
                acc_idx++;
            end
        end
    end

    logic          hold_p = 0;
    logic [AW-1:0] hd;
    logic [2:0]    hs;
    logic [AW-1:0] got_d [32];
    logic [2:0]    got_s [32];
    int            ngot = 0;

    always @(negedge clk) begin
        if (!rst) begin
            hold_p = 0;
        end else begin
            if (hold_p) begin
                chk("hold_valid", bus.out_valid, 1);
                chk("hold_data", bus.out_data, hd);
                chk("hold_slot", bus.out_slot, hs);
            end
            hold_p = 0;
            if (bus.out_valid) begin
                if (bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL extra_output: got %0h expected none",
                                 bus.out_data);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        chk("out_data", bus.out_data, e.d);
                        chk("out_slot", bus.out_slot, e.s);
                    end
                    if (ngot < 32) begin
                        got_d[ngot] = bus.out_data;
                        got_s[ngot] = bus.out_slot;
                        ngot++;
                    end
                end else begin
                    hold_p = 1;
                    hd = bus.out_data;
                    hs = bus.out_slot;
                end
            end
        end
    end

    always @(negedge clk) if (rst && bus.done) done_cnt++;

    task automatic check_quiet(input string tag);
        chk({tag, "_in_ready"}, bus.in_ready, 0);
        chk({tag, "_dot_ena"}, bus.dot_ena, 0);
        chk({tag, "_out_valid"}, bus.out_valid, 0);
        chk({tag, "_done"}, bus.done, 0);
        chk({tag, "_dot_acc"}, bus.dot_acc, 0);
        chk({tag, "_out_data"}, bus.out_data, 0);
        chk({tag, "_out_slot"}, bus.out_slot, 0);
    endtask

    task automatic start_job(input int k);
        k_eff   = (k == 0) ? 1 : k;
        acc_idx = 0;
        ngot    = 0;
        bus.k_len = KW'(k);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        feeding   = 1;
    endtask

    task automatic send(input logic [AW-1:0] p);
        int n = 0;
        cur_prod     = p;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 300) begin
            vectors++;
            miscompares++;
            $display("FAIL in_ready_timeout: got 0 expected 1");
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic feed(input int ke, input bit gaps);
        for (int i = 0; i < ke * L; i++) begin
            send(prod_tab[i]);
            if (gaps && i != ke * L - 1) begin
                @(posedge clk); #1;
            end
        end
        feeding = 0;
    endtask

    task automatic finish_job(input string tag, input int d0);
        int n = 0;
        while (done_cnt == d0 && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (12) @(posedge clk);
        #1;
        chk({tag, "_done_once"}, done_cnt - d0, 1);
        chk({tag, "_drained"}, exp_q.size(), 0);
    endtask

    initial begin
        int d0;
        bus.start     = 1'b0;
        bus.k_len     = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        cur_prod      = '0;
        for (int i = 0; i < L; i++) begin
            pipe[i] = '0;
            sums[i] = '0;
        end

        repeat (3) @(posedge clk);
        #1;
        check_quiet("reset");
        rst = 1'b1;
        @(posedge clk); #1;

        // k=1, results 1..8
        for (int i = 0; i < L; i++) prod_tab[i] = AW'(i + 1);
        d0 = done_cnt;
        start_job(1);
        feed(1, 0);
        finish_job("a", d0);
        chk("a_count", ngot, 8);
        for (int i = 0; i < L; i++) begin
            chk("a_lit_data", got_d[i], i + 1);
            chk("a_lit_slot", got_s[i], i);
        end

        // k=3, product 5 everywhere
        for (int i = 0; i < 3 * L; i++) prod_tab[i] = 32'd5;
        d0 = done_cnt;
        start_job(3);
        feed(3, 0);
        finish_job("b", d0);
        for (int i = 0; i < L; i++) chk("b_lit_data", got_d[i], 15);

        // k=2 with in_valid toggling
        for (int s = 0; s < L; s++) begin
            prod_tab[s]     = AW'(s + 1);
            prod_tab[L + s] = AW'(10 * (s + 1));
        end
        d0 = done_cnt;
        start_job(2);
        feed(2, 1);
        finish_job("c", d0);
        for (int s = 0; s < L; s++) chk("c_lit_data", got_d[s], 11 * (s + 1));

        // back-pressure across two jobs
        bus.out_ready = 1'b0;
        for (int s = 0; s < L; s++) prod_tab[s] = AW'(100 + s);
        d0 = done_cnt;
        start_job(1);
        feed(1, 0);
        while (done_cnt == d0) begin
            @(posedge clk); #1;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("d_full_valid", bus.out_valid, 1);
        for (int s = 0; s < L; s++) prod_tab[s] = AW'(200 + s);
        d0 = done_cnt;
        start_job(1);
        ngot = 0;
        fork
            feed(1, 0);
            begin
                repeat (20) begin
                    @(negedge clk);
                    chk("blocked_in_ready", bus.in_ready, 0);
                end
                @(posedge clk); #1;
                bus.out_ready = 1'b1;
            end
        join
        finish_job("e", d0);
        chk("e_count", ngot, 16);
        for (int s = 0; s < L; s++) begin
            chk("d_lit_data", got_d[s], 100 + s);
            chk("e_lit_data", got_d[L + s], 200 + s);
        end

        // reset while flushing
        for (int s = 0; s < L; s++) prod_tab[s] = 32'd7;
        d0 = done_cnt;
        start_job(1);
        feed(1, 0);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        exp_q.delete();
        #1;
        check_quiet("midrst");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("post_rst_valid", bus.out_valid, 0);
        end
        chk("post_rst_no_done", done_cnt - d0, 0);
        @(posedge clk); #1;

        // k_len=0 acts as 1
        for (int s = 0; s < L; s++) prod_tab[s] = 32'h7FFF_FFF0 + 32'(s);
        d0 = done_cnt;
        start_job(0);
        feed(1, 0);
        finish_job("g", d0);
        chk("g_count", ngot, 8);
        chk("g_lit_first", got_d[0], 32'h7FFF_FFF0);
        chk("g_lit_last", got_d[7], 32'h7FFF_FFF7);

        // modular wrap
        for (int s = 0; s < L; s++) begin
            prod_tab[s]     = (s == L - 1) ? 32'hFFFF_FFFF : 32'h7FFF_FFFF;
            prod_tab[L + s] = 32'd1;
        end
        d0 = done_cnt;
        start_job(2);
        feed(2, 0);
        finish_job("h", d0);
        for (int s = 0; s < L - 1; s++) chk("h_lit_wrap", got_d[s], 32'h8000_0000);
        chk("h_lit_zero", got_d[L-1], 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
